// File: rtl/rom_fetch_arbiter_if.sv
// Bus bundle between the two ROM requesters, the ROM reader and the fetch arbiter.
// The arbiter connects through the slave modport; the requester/ROM side uses master.
interface rom_fetch_arbiter_if #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 16
) ();
  logic                  a_req;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic                  a_ack;
  logic [DATA_WIDTH-1:0] a_data;
  logic                  b_req;
  logic [ADDR_WIDTH-1:0] b_addr;
  logic                  b_ack;
  logic [DATA_WIDTH-1:0] b_data;
  logic                  rom_start;
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic                  rom_done;
  logic [DATA_WIDTH-1:0] rom_data;
  logic                  busy;
  logic                  timeout;

  modport master (
    output a_req, a_addr, b_req, b_addr, rom_done, rom_data,
    input  a_ack, a_data, b_ack, b_data, rom_start, rom_addr, busy, timeout
  );

  modport slave (
    input  a_req, a_addr, b_req, b_addr, rom_done, rom_data,
    output a_ack, a_data, b_ack, b_data, rom_start, rom_addr, busy, timeout
  );
endinterface

// File: rtl/rom_fetch_arbiter.sv
// Round-robin arbiter sharing one ROM read port between an instruction fetch (A)
// and a secondary reader (B), with a WAIT-state timeout against a hung flash read.
module rom_fetch_arbiter #(
  parameter int ADDR_WIDTH     = 15,
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input logic              clk,
  input logic              reset_n,
  rom_fetch_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT    = 2'd2,
    S_RESPOND = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_last_b;
  logic                  r_grant_b;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_a_ack;
  logic                  r_b_ack;
  logic [DATA_WIDTH-1:0] r_a_data;
  logic [DATA_WIDTH-1:0] r_b_data;
  logic                  r_rom_start;
  logic [ADDR_WIDTH-1:0] r_rom_addr;
  logic                  r_busy;
  logic                  r_timeout;

  logic                  w_any_req;
  logic                  w_pick_b;
  logic                  w_grant;
  logic                  w_limit;
  logic                  w_grant_b_nxt;
  logic                  w_last_b_nxt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic                  w_a_ack_nxt;
  logic                  w_b_ack_nxt;
  logic [DATA_WIDTH-1:0] w_resp_data;
  logic [DATA_WIDTH-1:0] w_a_data_nxt;
  logic [DATA_WIDTH-1:0] w_b_data_nxt;
  logic                  w_rom_start_nxt;
  logic [ADDR_WIDTH-1:0] w_rom_addr_nxt;
  logic                  w_busy_nxt;
  logic                  w_timeout_nxt;

  // B wins only when A is idle or A held the previous grant.
  assign w_any_req = bus.a_req | bus.b_req;
  assign w_pick_b  = bus.b_req & (~bus.a_req | ~r_last_b);
  assign w_grant   = (r_state == S_IDLE) & w_any_req;
  assign w_limit   = (r_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_last_b    <= 1'b1;
      r_grant_b   <= 1'b0;
      r_cnt       <= {CNT_W{1'b0}};
      r_a_ack     <= 1'b0;
      r_b_ack     <= 1'b0;
      r_a_data    <= {DATA_WIDTH{1'b0}};
      r_b_data    <= {DATA_WIDTH{1'b0}};
      r_rom_start <= 1'b0;
      r_rom_addr  <= {ADDR_WIDTH{1'b0}};
      r_busy      <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_last_b    <= w_last_b_nxt;
      r_grant_b   <= w_grant_b_nxt;
      r_cnt       <= w_cnt_nxt;
      r_a_ack     <= w_a_ack_nxt;
      r_b_ack     <= w_b_ack_nxt;
      r_a_data    <= w_a_data_nxt;
      r_b_data    <= w_b_data_nxt;
      r_rom_start <= w_rom_start_nxt;
      r_rom_addr  <= w_rom_addr_nxt;
      r_busy      <= w_busy_nxt;
      r_timeout   <= w_timeout_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    w_state_nxt = w_any_req ? S_ISSUE : S_IDLE;
      S_ISSUE:   w_state_nxt = S_WAIT;
      S_WAIT:    w_state_nxt = (bus.rom_done || w_limit) ? S_RESPOND : S_WAIT;
      S_RESPOND: w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // A rom_done coinciding with the limit beats the timeout.
  always_comb begin
    w_grant_b_nxt   = w_grant ? w_pick_b : r_grant_b;
    w_last_b_nxt    = w_grant ? w_pick_b : r_last_b;
    w_rom_addr_nxt  = w_grant ? (w_pick_b ? bus.b_addr : bus.a_addr) : r_rom_addr;
    w_rom_start_nxt = w_grant;
    w_busy_nxt      = (w_state_nxt != S_IDLE);
    w_timeout_nxt   = (r_state == S_WAIT) & ~bus.rom_done & w_limit;
    w_a_ack_nxt     = (w_state_nxt == S_RESPOND) & ~r_grant_b;
    w_b_ack_nxt     = (w_state_nxt == S_RESPOND) & r_grant_b;
    w_resp_data     = bus.rom_done ? bus.rom_data : {DATA_WIDTH{1'b1}};
    w_a_data_nxt    = w_a_ack_nxt ? w_resp_data : r_a_data;
    w_b_data_nxt    = w_b_ack_nxt ? w_resp_data : r_b_data;
    case (r_state)
      S_ISSUE: w_cnt_nxt = {CNT_W{1'b0}};
      S_WAIT:  w_cnt_nxt = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      default: w_cnt_nxt = r_cnt;
    endcase
  end

  assign bus.a_ack     = r_a_ack;
  assign bus.b_ack     = r_b_ack;
  assign bus.a_data    = r_a_data;
  assign bus.b_data    = r_b_data;
  assign bus.rom_start = r_rom_start;
  assign bus.rom_addr  = r_rom_addr;
  assign bus.busy      = r_busy;
  assign bus.timeout   = r_timeout;
endmodule

// File: tb/tb_rom_fetch_arbiter.sv
// Directed bench for rom_fetch_arbiter; cycle numbers in comments count from the
// IDLE cycle in which the request is first presented.
module tb_rom_fetch_arbiter;
  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  rom_fetch_arbiter_if #(.ADDR_WIDTH(15), .DATA_WIDTH(16)) bus ();

  rom_fetch_arbiter #(
    .ADDR_WIDTH(15),
    .DATA_WIDTH(16),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n      = 1'b0;
    bus.a_req    = 1'b0;
    bus.b_req    = 1'b0;
    bus.a_addr   = 15'h0000;
    bus.b_addr   = 15'h0000;
    bus.rom_done = 1'b0;
    bus.rom_data = 16'h0000;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({bus.a_ack, bus.b_ack, bus.rom_start, bus.timeout, bus.busy} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_flags: a_ack,b_ack,start,timeout,busy=%b required 00000",
               {bus.a_ack, bus.b_ack, bus.rom_start, bus.timeout, bus.busy});
    end
    checks++;
    if ({bus.a_data, bus.b_data, bus.rom_addr} !== 47'h0) begin
      errors++;
      $display("FAIL reset_data: a_data=%h b_data=%h rom_addr=%h required 0/0/0",
               bus.a_data, bus.b_data, bus.rom_addr);
    end
  endtask

  task automatic test_single_read();
    bus.a_req  = 1'b1;
    bus.a_addr = 15'h0005;
    tick(); // c1
    checks++;
    if (bus.rom_start !== 1'b1 || bus.rom_addr !== 15'h0005) begin
      errors++;
      $display("FAIL single_issue: start=%b addr=%h required 1/0005", bus.rom_start, bus.rom_addr);
    end
    for (int c = 2; c <= 3; c++) begin
      tick();
      checks++;
      if ({bus.busy, bus.rom_start, bus.a_ack, bus.b_ack} !== 4'b1000) begin
        errors++;
        $display("FAIL single_wait c%0d: busy,start,a_ack,b_ack=%b required 1000", c,
                 {bus.busy, bus.rom_start, bus.a_ack, bus.b_ack});
      end
    end
    bus.rom_done = 1'b1; // c3: done two cycles after start
    bus.rom_data = 16'h1234;
    tick(); // c4
    bus.rom_done = 1'b0;
    checks++;
    if (bus.a_ack !== 1'b1 || bus.a_data !== 16'h1234 || bus.b_ack !== 1'b0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL single_ack: a_ack=%b a_data=%h b_ack=%b busy=%b required 1/1234/0/1",
               bus.a_ack, bus.a_data, bus.b_ack, bus.busy);
    end
    bus.a_req = 1'b0;
    tick(); // c5
    checks++;
    if (bus.a_ack !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL single_idle: a_ack=%b busy=%b required 0/0", bus.a_ack, bus.busy);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    bus.a_req  = 1'b1;
    bus.b_req  = 1'b1;
    bus.a_addr = 15'h0010;
    bus.b_addr = 15'h0020;
    for (int i = 0; i < 6; i++) begin
      logic        exp_b;
      logic [14:0] exp_addr;
      logic [15:0] exp_bd;
      exp_b    = (i % 2) == 1;
      exp_addr = exp_b ? 15'h0020 : 15'h0010;
      exp_bd   = (i >= 1) ? 16'hBBBB : 16'h0000;
      tick();
      checks++;
      if (bus.rom_start !== 1'b1 || bus.rom_addr !== exp_addr) begin
        errors++;
        $display("FAIL rr_issue txn%0d: start=%b addr=%h required 1/%h", i, bus.rom_start, bus.rom_addr, exp_addr);
      end
      tick();
      bus.rom_done = 1'b1;
      bus.rom_data = exp_b ? 16'hBBBB : 16'hAAAA;
      tick();
      bus.rom_done = 1'b0;
      checks++;
      if (bus.a_ack !== ~exp_b || bus.b_ack !== exp_b || bus.a_data !== 16'hAAAA || bus.b_data !== exp_bd) begin
        errors++;
        $display("FAIL rr_ack txn%0d: a_ack=%b b_ack=%b a_data=%h b_data=%h required %b/%b/AAAA/%h",
                 i, bus.a_ack, bus.b_ack, bus.a_data, bus.b_data, ~exp_b, exp_b, exp_bd);
      end
      if (i == 5) begin
        bus.a_req = 1'b0;
        bus.b_req = 1'b0;
      end
      tick();
    end
  endtask

  task automatic test_timeout();
    bus.a_req  = 1'b1;
    bus.a_addr = 15'h0100;
    tick(); // c1
    checks++;
    if (bus.rom_start !== 1'b1 || bus.rom_addr !== 15'h0100) begin
      errors++;
      $display("FAIL to_issue: start=%b addr=%h required 1/0100", bus.rom_start, bus.rom_addr);
    end
    tick(); // c2
    for (int c = 2; c <= 9; c++) begin
      checks++;
      if ({bus.busy, bus.a_ack, bus.timeout} !== 3'b100) begin
        errors++;
        $display("FAIL to_wait c%0d: busy,a_ack,timeout=%b required 100", c, {bus.busy, bus.a_ack, bus.timeout});
      end
      tick();
    end
    checks++; // c10
    if (bus.a_ack !== 1'b1 || bus.a_data !== 16'hFFFF || bus.timeout !== 1'b1 || bus.b_data !== 16'hBBBB) begin
      errors++;
      $display("FAIL to_resp: a_ack=%b a_data=%h timeout=%b b_data=%h required 1/FFFF/1/BBBB",
               bus.a_ack, bus.a_data, bus.timeout, bus.b_data);
    end
    bus.a_req = 1'b0;
    tick(); // c11
    checks++;
    if ({bus.timeout, bus.busy, bus.a_ack} !== 3'b000) begin
      errors++;
      $display("FAIL to_idle: timeout,busy,a_ack=%b required 000", {bus.timeout, bus.busy, bus.a_ack});
    end
    bus.a_req  = 1'b1;
    bus.a_addr = 15'h0101;
    tick();
    checks++;
    if (bus.rom_start !== 1'b1 || bus.rom_addr !== 15'h0101) begin
      errors++;
      $display("FAIL to_next_issue: start=%b addr=%h required 1/0101", bus.rom_start, bus.rom_addr);
    end
    tick();
    bus.rom_done = 1'b1;
    bus.rom_data = 16'h5555;
    tick();
    bus.rom_done = 1'b0;
    checks++;
    if (bus.a_ack !== 1'b1 || bus.a_data !== 16'h5555 || bus.timeout !== 1'b0) begin
      errors++;
      $display("FAIL to_next_ack: a_ack=%b a_data=%h timeout=%b required 1/5555/0", bus.a_ack, bus.a_data, bus.timeout);
    end
    bus.a_req = 1'b0;
    tick();
  endtask

  task automatic test_timeout_race();
    bus.a_req  = 1'b1;
    bus.a_addr = 15'h0200;
    tick(); // c1
    tick(); // c2
    repeat (7) tick(); // c9: last allowed WAIT cycle
    bus.rom_done = 1'b1;
    bus.rom_data = 16'h0F0F;
    tick(); // c10
    bus.rom_done = 1'b0;
    checks++;
    if (bus.a_ack !== 1'b1 || bus.a_data !== 16'h0F0F || bus.timeout !== 1'b0) begin
      errors++;
      $display("FAIL race_resp: a_ack=%b a_data=%h timeout=%b required 1/0F0F/0", bus.a_ack, bus.a_data, bus.timeout);
    end
    bus.a_req = 1'b0;
    tick();
    checks++;
    if (bus.timeout !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL race_idle: timeout=%b busy=%b required 0/0", bus.timeout, bus.busy);
    end
  endtask

  task automatic test_reset_mid_wait();
    bus.a_req  = 1'b1;
    bus.a_addr = 15'h0300;
    tick(); // c1
    tick(); // c2
    tick(); // c3
    reset_n   = 1'b0;
    bus.a_req = 1'b0;
    tick(); // c4
    reset_n      = 1'b1;
    bus.rom_done = 1'b1; // stray completion in IDLE
    bus.rom_data = 16'hDEAD;
    checks++;
    if ({bus.a_ack, bus.b_ack, bus.rom_start, bus.timeout, bus.busy} !== 5'b00000 ||
        {bus.a_data, bus.b_data, bus.rom_addr} !== 47'h0) begin
      errors++;
      $display("FAIL midrst_state: flags=%b a_data=%h b_data=%h rom_addr=%h required 00000/0/0/0",
               {bus.a_ack, bus.b_ack, bus.rom_start, bus.timeout, bus.busy}, bus.a_data, bus.b_data, bus.rom_addr);
    end
    tick(); // c5
    bus.rom_done = 1'b0;
    checks++;
    if ({bus.a_ack, bus.b_ack, bus.busy} !== 3'b000 || bus.a_data !== 16'h0000) begin
      errors++;
      $display("FAIL midrst_stray: a_ack,b_ack,busy=%b a_data=%h required 000/0000",
               {bus.a_ack, bus.b_ack, bus.busy}, bus.a_data);
    end
    bus.a_req  = 1'b1;
    bus.a_addr = 15'h0301;
    tick();
    checks++;
    if (bus.rom_start !== 1'b1 || bus.rom_addr !== 15'h0301) begin
      errors++;
      $display("FAIL midrst_issue: start=%b addr=%h required 1/0301", bus.rom_start, bus.rom_addr);
    end
    tick();
    bus.rom_done = 1'b1;
    bus.rom_data = 16'h7777;
    tick();
    bus.rom_done = 1'b0;
    checks++;
    if (bus.a_ack !== 1'b1 || bus.a_data !== 16'h7777) begin
      errors++;
      $display("FAIL midrst_ack: a_ack=%b a_data=%h required 1/7777", bus.a_ack, bus.a_data);
    end
    bus.a_req = 1'b0;
    tick();
  endtask

  task automatic test_addr_change();
    bus.b_req  = 1'b1;
    bus.b_addr = 15'h0400;
    tick(); // c1: grant already taken, requester misbehaves
    bus.b_addr = 15'h7FFF;
    bus.b_req  = 1'b0;
    checks++;
    if (bus.rom_start !== 1'b1 || bus.rom_addr !== 15'h0400) begin
      errors++;
      $display("FAIL chg_issue: start=%b addr=%h required 1/0400", bus.rom_start, bus.rom_addr);
    end
    tick(); // c2
    checks++;
    if (bus.rom_addr !== 15'h0400) begin
      errors++;
      $display("FAIL chg_hold: addr=%h required 0400", bus.rom_addr);
    end
    bus.rom_done = 1'b1;
    bus.rom_data = 16'h4321;
    tick(); // c3
    bus.rom_done = 1'b0;
    checks++;
    if (bus.b_ack !== 1'b1 || bus.b_data !== 16'h4321 || bus.a_ack !== 1'b0 || bus.a_data !== 16'h7777) begin
      errors++;
      $display("FAIL chg_ack: b_ack=%b b_data=%h a_ack=%b a_data=%h required 1/4321/0/7777",
               bus.b_ack, bus.b_data, bus.a_ack, bus.a_data);
    end
    tick(); // c4
    tick(); // c5
    checks++;
    if ({bus.b_ack, bus.busy, bus.rom_start} !== 3'b000) begin
      errors++;
      $display("FAIL chg_idle: b_ack,busy,start=%b required 000", {bus.b_ack, bus.busy, bus.rom_start});
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single_read();
    test_round_robin();
    test_timeout();
    test_timeout_race();
    test_reset_mid_wait();
    test_addr_change();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rom_fetch_arbiter.md
Name: rom_fetch_arbiter

Overview:
Shares the single SPI-flash-backed ROM read port between two requesters. Port A is the CPU instruction fetch; port B is a secondary reader, such as the Screen/debug path. It grants requesters round-robin, issues one read at a time to the ROM reader, waits for completion, and returns the word to the granted requester with a one-cycle ack. A timeout guards against a hung flash transaction.

Parameters:
ADDR_WIDTH, 15, ROM word address width
DATA_WIDTH, 16, ROM word width
TIMEOUT_CYCLES, 1023, maximum cycles spent in WAIT before forcing a response (must be >= 1)

Ports:
clk  in  1  system clock (12 MHz board clock)
reset_n  in  1  synchronous, active-low reset
a_req  in  1  requester A read request (level)
a_addr  in  ADDR_WIDTH  requester A address
a_ack  out  1  requester A completion pulse
a_data  out  DATA_WIDTH  requester A read data
b_req  in  1  requester B read request (level)
b_addr  in  ADDR_WIDTH  requester B address
b_ack  out  1  requester B completion pulse
b_data  out  DATA_WIDTH  requester B read data
rom_start  out  1  one-cycle start pulse to ROM reader
rom_addr  out  ADDR_WIDTH  address to ROM reader
rom_done  in  1  ROM reader completion pulse
rom_data  in  DATA_WIDTH  ROM read data, valid with rom_done
busy  out  1  high in every state except IDLE
timeout  out  1  one-cycle pulse when a read is aborted by timeout

Behaviour:
- Reset (reset_n low at a clk edge) forces the following:
  - state IDLE
  - a_ack = b_ack = rom_start = timeout = busy = 0
  - a_data = b_data = rom_addr = 0
  - last_grant = B, so A wins the first tie
  - timeout counter = 0
- Reset mid-transaction abandons the transaction. The arbiter issues no abort to the ROM reader. A stray rom_done in IDLE/ISSUE is ignored.
- States are IDLE, ISSUE, WAIT, RESPOND. All outputs are registered.
- IDLE:
  - Only one req high: grant it.
  - Both high: grant the requester not equal to last_grant.
  - On grant: latch the granted address into rom_addr, update last_grant, go to ISSUE.
  - No req: stay in IDLE.
- ISSUE: rom_start = 1 for exactly this cycle; clear the timeout counter; go to WAIT.
- WAIT:
  - rom_addr is held stable.
  - On rom_done: capture rom_data into the granted port's data register and go to RESPOND.
  - Otherwise increment the counter. When it reaches TIMEOUT_CYCLES, load all-ones into the granted data register, pulse timeout in the RESPOND cycle, and go to RESPOND.
  - rom_done in the same cycle the limit is reached: rom_done wins, and timeout is not pulsed.
- RESPOND: the granted port's ack = 1 for exactly this cycle; go to IDLE.
- Latency: req high in IDLE at cycle 0 gives rom_start in cycle 1. rom_done in cycle k (k >= 2) gives ack in cycle k+1. The minimum request-to-ack time is 3 cycles.
- Data registers:
  - The data register of the port that is acked changes only on that port's completion.
  - It holds its value until that port's next completion.
  - The other port's data and ack are untouched.
- Protocol:
  - A requester holds req and addr stable until it sees ack. It deasserts req in the cycle after ack, i.e. registered clear on ack.
  - The arbiter samples addr only at grant; later changes are ignored.
  - req dropped before ack does not cancel a granted transaction; ack is still pulsed.
- Starvation: with both requesters continuously requesting, grants alternate A, B, A, B. Neither waits more than one full transaction.
- rom_done outside WAIT is ignored in all cases.

Test Plan:
- Reset, then a_req=1, a_addr=0x0005. ROM model returns 0x1234 with rom_done 2 cycles after rom_start. Required: rom_start in cycle 1 with rom_addr=0x0005; a_ack in cycle 4 with a_data=0x1234; b_ack stays 0; busy high cycles 1-4.
- a_req and b_req both asserted in the same cycle after reset, addrs 0x0010/0x0020, data 0xAAAA/0xBBBB. Required: A served first (a_data=0xAAAA), then B (b_data=0xBBBB). Under continuous requests over 6 transactions, grant order is A, B, A, B, A, B.
- TIMEOUT_CYCLES=8, ROM model never asserts rom_done. Required: ack for the granted port with data=0xFFFF, timeout pulsed once, arbiter back in IDLE, next request served normally.
- TIMEOUT_CYCLES=8, rom_done asserted in exactly the cycle the counter hits the limit, rom_data=0x0F0F. Required: data=0x0F0F, timeout stays 0.
- reset_n pulsed low during WAIT, followed by a stray rom_done. Required: all outputs return to reset values, no ack generated, and the next a_req is granted normally.
- b_addr changed and b_req dropped one cycle after B's grant. Required: rom_addr keeps the originally latched address, b_ack still pulses, and a_data is unchanged.
